// File: rtl/x_stream_source.sv
// x_stream_source: holds one SIZE_X-word vector and streams it
// num_frames times over a valid/ready port with a 2-entry skid.
module x_stream_source #(
  parameter  int WIDTH      = 16,
  parameter  int SIZE_X     = 32,
  parameter  int MAX_FRAMES = 255,
  localparam int LOGSIZE_X  = $clog2(SIZE_X),
  localparam int LOGFRAMES  = $clog2(MAX_FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [LOGSIZE_X-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 start,
  input  logic [LOGFRAMES-1:0] num_frames,
  output logic [WIDTH-1:0]     x_data,
  output logic                 x_valid,
  input  logic                 x_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  localparam logic [LOGSIZE_X-1:0] LAST_W = LOGSIZE_X'(SIZE_X - 1);
  localparam logic [LOGFRAMES-1:0] ONE_F  = LOGFRAMES'(1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]     mem [SIZE_X];
  logic [WIDTH-1:0]     mem_q;
  logic                 q_valid;
  logic [WIDTH-1:0]     skid_data;
  logic                 skid_valid;

  logic [LOGSIZE_X-1:0] rd_addr;
  logic [LOGFRAMES-1:0] rd_frame;
  logic                 rd_done;
  logic [LOGSIZE_X-1:0] tx_word;
  logic [LOGFRAMES-1:0] tx_frame;
  logic [LOGFRAMES-1:0] frames;

  logic       go;
  logic       go_zero;
  logic       xfer;
  logic       pop;
  logic       rd_en;
  logic       rd_last;
  logic       last_xfer;
  logic [1:0] occ;

  assign busy = (state != IDLE);

  // Handshake, occupancy and read-issue decisions
  always_comb begin
    go        = (state == IDLE) && start && (num_frames != '0);
    go_zero   = (state == IDLE) && start && (num_frames == '0);
    xfer      = x_valid && x_ready;
    pop       = !x_valid || xfer;
    // words held in out/skid after this edge, before the new read lands
    occ       = 2'(x_valid) + 2'(skid_valid) + 2'(q_valid) - 2'(xfer);
    rd_en     = (state != IDLE) && !rd_done && (occ <= 2'd1);
    rd_last   = (rd_addr == LAST_W) && (rd_frame == frames - ONE_F);
    last_xfer = xfer && (tx_word == LAST_W)
                && (tx_frame == frames - ONE_F);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = PRIME;
      PRIME:   state_nx = STREAM;
      STREAM:  if (last_xfer) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Vector storage: writes only while idle, registered read
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    if (rd_en)          mem_q <= mem[rd_addr];
  end

  // Read/transfer counters and the done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr  <= '0;
      rd_frame <= '0;
      rd_done  <= 1'b0;
      tx_word  <= '0;
      tx_frame <= '0;
      frames   <= '0;
      q_valid  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done    <= go_zero || last_xfer;
      q_valid <= rd_en;
      if (go) begin
        frames   <= num_frames;
        rd_addr  <= '0;
        rd_frame <= '0;
        rd_done  <= 1'b0;
        tx_word  <= '0;
        tx_frame <= '0;
      end else begin
        if (rd_en) begin
          rd_addr <= (rd_addr == LAST_W) ? '0 : rd_addr + 1'b1;
          if (rd_addr == LAST_W) rd_frame <= rd_frame + ONE_F;
          if (rd_last)           rd_done  <= 1'b1;
        end
        if (xfer) begin
          tx_word <= (tx_word == LAST_W) ? '0 : tx_word + 1'b1;
          if (tx_word == LAST_W) tx_frame <= tx_frame + ONE_F;
        end
      end
    end
  end

  // Output register plus skid slot fed by the read pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_data     <= '0;
      x_valid    <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        x_data     <= skid_data;
        x_valid    <= 1'b1;
        skid_valid <= q_valid;
        if (q_valid) skid_data <= mem_q;
      end else if (q_valid) begin
        x_data  <= mem_q;
        x_valid <= 1'b1;
      end else begin
        x_valid <= 1'b0;
      end
    end else if (q_valid) begin
      skid_data  <= mem_q;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_x_stream_source.sv
// tb_x_stream_source: table-driven stream scenarios plus
// hand-written reset, busy-write and zero-frame sequences.
module tb_x_stream_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [7:0]  num_frames;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  x_stream_source dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .num_frames (num_frames),
    .x_data     (x_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frames;
    int mode;
    int exp_xfers;
    int exp_first;
    int exp_end;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: random ready + 10-cycle stall at
  // word 15; 2: ready toggles; 3: ready high + busy write/start
  task automatic run_case(input vec_t v);
    int n = 0;
    int c = 0;
    int first = -1;
    int last_pt = -1;
    int done_pt = -1;
    int done_cnt = 0;
    int stall_left = 0;
    bit stall_used = 0;
    bit stalled_prev = 0;
    bit fin = 0;
    logic [15:0] prev_data = '0;
    logic rdy;
    num_frames = 8'(v.frames);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    while (!fin && c < 3000) begin
      wr_en = 1'b0;
      start = 1'b0;
      rdy = 1'b1;
      if (v.mode == 1) begin
        if (n == 15 && !stall_used) begin
          stall_used = 1;
          stall_left = 10;
        end
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = 1'($urandom_range(0, 1));
        end
      end else if (v.mode == 2) begin
        rdy = 1'(c % 2);
      end else if (v.mode == 3 && c == 3) begin
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 16'h7FFF;
        start = 1'b1;
        num_frames = 8'd3;
      end
      x_ready = rdy;
      if (done) begin
        done_cnt++;
        done_pt = c;
      end
      if (x_valid && first < 0) first = c;
      if (stalled_prev) begin
        chk("hold_valid", 32'(x_valid), 1);
        chk("hold_data", 32'(x_data), 32'(prev_data));
      end
      if (x_valid && rdy) begin
        chk("data", 32'(x_data), 32'(100 + n % 32));
        n++;
        last_pt = c;
      end
      stalled_prev = x_valid && !rdy;
      prev_data = x_data;
      if (!busy) fin = 1;
      else begin
        tick();
        c++;
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("finished", 32'(fin), 1);
    chk("xfer_count", 32'(n), 32'(v.exp_xfers));
    chk("first_valid", 32'(first), 32'(v.exp_first));
    chk("done_count", 32'(done_cnt), 1);
    chk("done_at_end", 32'(done_pt), 32'(c));
    chk("busy_falls_last", 32'(last_pt), 32'(c - 1));
    if (v.exp_end >= 0) chk("end_cycle", 32'(c), 32'(v.exp_end));
    x_ready = 1'b1;
    tick();
    chk("done_drop", 32'(done), 0);
    chk("valid_idle", 32'(x_valid), 0);
  endtask

  initial begin
    int n;
    int guard;
    int bad;
    vecs[0] = '{frames: 1, mode: 0, exp_xfers: 32,
                exp_first: 2, exp_end: 34};
    vecs[1] = '{frames: 3, mode: 0, exp_xfers: 96,
                exp_first: 2, exp_end: 98};
    vecs[2] = '{frames: 1, mode: 1, exp_xfers: 32,
                exp_first: 2, exp_end: -1};
    vecs[3] = '{frames: 1, mode: 3, exp_xfers: 32,
                exp_first: 2, exp_end: 34};

    reset = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    num_frames = '0;
    x_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(x_valid), 0);
    chk("rst_data", 32'(x_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      wr_addr = 5'(i);
      wr_data = 16'(i + 100);
      tick();
    end
    wr_en = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) run_case(vecs[k]);

    // ready toggling every cycle across two frames
    run_case('{frames: 2, mode: 2, exp_xfers: 64,
               exp_first: 2, exp_end: -1});

    // reset mid-stream after 10 transfers
    num_frames = 8'd1;
    x_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    guard = 0;
    while (n < 10 && guard < 200) begin
      if (x_valid) n++;
      tick();
      guard++;
    end
    chk("pre_reset_xfers", 32'(n), 10);
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(x_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_done", 32'(done), 0);
    chk("post_reset_busy", 32'(busy), 0);
    run_case(vecs[0]);

    // zero-frame start
    num_frames = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_valid", 32'(x_valid), 0);
    tick();
    chk("zero_done_drop", 32'(done), 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (x_valid || busy || done) bad++;
      tick();
    end
    chk("zero_quiet", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
